// File: rtl/sent_pkg.sv
// Shared SENT constants, TX state encoding and nibble pulse-length helper.
// Used by the transmit pulse generator and by the receive pulse/CRC checks.
package sent_pkg;

  localparam int SYNC_TICKS        = 56;
  localparam int NIBBLE_BASE_TICKS = 12;
  localparam int NIBBLES_PER_FRAME = 6;

  localparam logic [3:0] CRC_SEED = 4'b0101;
  localparam logic [3:0] CRC_POLY = 4'b1101;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SYNC,
    TX_STATUS,
    TX_DATA,
    TX_CRC,
    TX_PAUSE
  } tx_state_t;

  function automatic logic [9:0] nibble_ticks(input logic [3:0] nib);
    return 10'(NIBBLE_BASE_TICKS) + {6'd0, nib};
  endfunction

endpackage

// File: rtl/sent_crc4_nibble.sv
// Combinational SENT 4-bit CRC step: shifts one nibble in MSB-first.
// Shared between the transmit encoder and the receive CRC check.
module sent_crc4_nibble
  import sent_pkg::*;
(
  input  logic [3:0] crc_in,
  input  logic [3:0] nibble,
  output logic [3:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 3; i >= 0; i--) begin
      crc_out = {crc_out[2:0], nibble[i]} ^ (crc_out[3] ? CRC_POLY : 4'b0000);
    end
  end

endmodule

// File: rtl/sent_tx_pulse_gen.sv
// SENT fast-channel transmitter: holding register, tick prescaler, pulse FSM
// and CRC, driving a single idle-high line with fixed-low-phase pulses.
module sent_tx_pulse_gen
  import sent_pkg::*;
#(
  parameter int unsigned CLK_PER_TICK = 3,
  parameter int unsigned LOW_TICKS    = 5,
  parameter bit          PAUSE_EN     = 1'b1,
  parameter int unsigned FRAME_TICKS  = 284
) (
  input  logic        clk_tx,
  input  logic        reset_tx,
  input  logic        frame_valid_i,
  input  logic [3:0]  status_nibble_i,
  input  logic [23:0] data_nibbles_i,
  output logic        frame_ready_o,
  output logic        data_pulse_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [3:0]  crc_o
);

  localparam int PRE_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_TICK - 1);
  localparam logic [9:0] LOW_T  = 10'(LOW_TICKS);
  localparam logic [9:0] SYNC_T = 10'(SYNC_TICKS);
  // Pause absorbs whatever the nibble values did not use, keeping the frame length fixed.
  localparam logic [9:0] PAUSE_BASE =
    10'(FRAME_TICKS - SYNC_TICKS - 8 * NIBBLE_BASE_TICKS);

  tx_state_t        state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [9:0]       tick_q, tick_d;
  logic [9:0]       len_q, len_d;
  logic [2:0]       nib_cnt_q, nib_cnt_d;
  logic [23:0]      data_sr_q, data_sr_d;
  logic [3:0]       status_q, status_d;
  logic             hold_full_q, hold_full_d;
  logic [3:0]       hold_status_q, hold_status_d;
  logic [23:0]      hold_data_q, hold_data_d;
  logic [3:0]       crc_q, crc_d;
  logic [6:0]       sum_q, sum_d;
  logic             data_pulse_q, data_pulse_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic       tick_end;
  logic       pulse_end;
  logic       start_frame;
  logic       last_pulse;
  logic [3:0] cur_nib;
  logic [3:0] crc_upd;
  logic [3:0] crc_aug;

  assign cur_nib = data_sr_q[23:20];

  sent_crc4_nibble u_crc_upd (
    .crc_in  (crc_q),
    .nibble  (cur_nib),
    .crc_out (crc_upd)
  );

  sent_crc4_nibble u_crc_aug (
    .crc_in  (crc_upd),
    .nibble  (4'b0000),
    .crc_out (crc_aug)
  );

  // Handshake: a frame is taken on any edge with frame_valid_i && frame_ready_o;
  // ready stays low while the holding register is full and rises the cycle the
  // held frame is moved into the shift register at sync start.
  always_comb begin
    state_d       = state_q;
    pre_d         = pre_q;
    tick_d        = tick_q;
    len_d         = len_q;
    nib_cnt_d     = nib_cnt_q;
    data_sr_d     = data_sr_q;
    status_d      = status_q;
    hold_full_d   = hold_full_q;
    hold_status_d = hold_status_q;
    hold_data_d   = hold_data_q;
    crc_d         = crc_q;
    sum_d         = sum_q;
    start_frame   = 1'b0;

    tick_end  = (pre_q == PRE_LAST);
    pulse_end = tick_end && (tick_q == len_q - 10'd1);

    if (state_q != TX_IDLE) begin
      pre_d  = tick_end ? '0 : pre_q + 1'b1;
      tick_d = tick_end ? tick_q + 10'd1 : tick_q;
      if (pulse_end) begin
        tick_d = '0;
      end
    end

    case (state_q)
      TX_IDLE: begin
        pre_d       = '0;
        tick_d      = '0;
        start_frame = hold_full_q;
      end
      TX_SYNC: begin
        if (pulse_end) begin
          state_d = TX_STATUS;
          len_d   = nibble_ticks(status_q);
          sum_d   = 7'(status_q);
        end
      end
      TX_STATUS: begin
        if (pulse_end) begin
          state_d   = TX_DATA;
          len_d     = nibble_ticks(cur_nib);
          sum_d     = sum_q + 7'(cur_nib);
          data_sr_d = {data_sr_q[19:0], 4'd0};
          nib_cnt_d = '0;
          crc_d     = crc_upd;
        end
      end
      TX_DATA: begin
        if (pulse_end) begin
          if (nib_cnt_q == 3'(NIBBLES_PER_FRAME - 1)) begin
            state_d = TX_CRC;
            len_d   = nibble_ticks(crc_q);
            sum_d   = sum_q + 7'(crc_q);
          end else begin
            len_d     = nibble_ticks(cur_nib);
            sum_d     = sum_q + 7'(cur_nib);
            data_sr_d = {data_sr_q[19:0], 4'd0};
            nib_cnt_d = nib_cnt_q + 3'd1;
            // The zero augment is folded into the load of the last data nibble.
            crc_d     = (nib_cnt_q == 3'(NIBBLES_PER_FRAME - 2)) ? crc_aug : crc_upd;
          end
        end
      end
      TX_CRC: begin
        if (pulse_end) begin
          if (PAUSE_EN) begin
            state_d = TX_PAUSE;
            len_d   = PAUSE_BASE - {3'd0, sum_q};
          end else if (hold_full_q) begin
            start_frame = 1'b1;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      TX_PAUSE: begin
        if (pulse_end) begin
          if (hold_full_q) begin
            start_frame = 1'b1;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    if (start_frame) begin
      state_d     = TX_SYNC;
      pre_d       = '0;
      tick_d      = '0;
      len_d       = SYNC_T;
      data_sr_d   = hold_data_q;
      status_d    = hold_status_q;
      hold_full_d = 1'b0;
      crc_d       = CRC_SEED;
      sum_d       = '0;
      nib_cnt_d   = '0;
    end

    if (frame_valid_i && ready_q) begin
      hold_full_d   = 1'b1;
      hold_status_d = status_nibble_i;
      hold_data_d   = data_nibbles_i;
    end

    last_pulse   = PAUSE_EN ? (state_d == TX_PAUSE) : (state_d == TX_CRC);
    busy_d       = (state_d != TX_IDLE);
    data_pulse_d = (state_d == TX_IDLE) || (tick_d >= LOW_T);
    ready_d      = !hold_full_d;
    done_d       = last_pulse && (tick_d == len_d - 10'd1) && (pre_d == PRE_LAST);
  end

  always_ff @(posedge clk_tx) begin
    if (reset_tx) begin
      state_q       <= TX_IDLE;
      pre_q         <= '0;
      tick_q        <= '0;
      len_q         <= SYNC_T;
      nib_cnt_q     <= '0;
      data_sr_q     <= '0;
      status_q      <= '0;
      hold_full_q   <= 1'b0;
      hold_status_q <= '0;
      hold_data_q   <= '0;
      crc_q         <= CRC_SEED;
      sum_q         <= '0;
      data_pulse_q  <= 1'b1;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pre_q         <= pre_d;
      tick_q        <= tick_d;
      len_q         <= len_d;
      nib_cnt_q     <= nib_cnt_d;
      data_sr_q     <= data_sr_d;
      status_q      <= status_d;
      hold_full_q   <= hold_full_d;
      hold_status_q <= hold_status_d;
      hold_data_q   <= hold_data_d;
      crc_q         <= crc_d;
      sum_q         <= sum_d;
      data_pulse_q  <= data_pulse_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign frame_ready_o = ready_q;
  assign data_pulse_o  = data_pulse_q;
  assign busy_o        = busy_q;
  assign frame_done_o  = done_q;
  assign crc_o         = crc_q;

endmodule
